alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: Moore control sequencer that fetches one instruction and issues ALU datapath strobes per T state.
// Define ALU_SEQ_MULDIV_EN to compile in MUL/DIV sequencing (T6, HIin/LOin/Zhighin/Zhighout).
module alu_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        PCin,
  output logic        MDMuxread,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [12:0] alu_op,
  output logic        halted,
  output logic        busy
);

  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

  state_t     state;
  logic       t1_first;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_binary, is_unary, is_muldiv, legal;
  logic [3:0] alu_idx;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];

  always_comb begin
    is_binary = 1'b0;
    is_unary  = 1'b0;
    is_muldiv = 1'b0;
    alu_idx   = '0;
    case (opcode)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
        is_binary = 1'b1;
        alu_idx   = 4'(opcode - 5'd3);
      end
`ifdef ALU_SEQ_MULDIV_EN
      5'd15: begin is_muldiv = 1'b1; alu_idx = 4'd9;  end
      5'd16: begin is_muldiv = 1'b1; alu_idx = 4'd10; end
`endif
      5'd17: begin is_unary = 1'b1; alu_idx = 4'd11; end
      5'd18: begin is_unary = 1'b1; alu_idx = 4'd12; end
      default: ;
    endcase
  end

  assign legal = is_binary | is_unary | is_muldiv;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= IDLE;
      t1_first <= 1'b0;
    end else begin
      // Marks the first cycle spent in T1, when the incremented PC is written back.
      t1_first <= (state == T0);
      case (state)
        IDLE:    if (run) state <= T0;
        T0:      state <= T1;
        T1:      if (mem_ready) state <= T2;
        T2:      state <= T3;
        T3:      state <= legal ? T4 : HALT;
        T4:      state <= T5;
        T5:      if (is_muldiv) state <= T6;
                 else state <= run ? T0 : IDLE;
        T6:      state <= run ? T0 : IDLE;
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    PCout     = 1'b0;
    MARin     = 1'b0;
    IncPC     = 1'b0;
    PCin      = 1'b0;
    MDMuxread = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zlowin    = 1'b0;
    Zhighin   = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    Rin       = '0;
    Rout      = '0;
    alu_op    = '0;
    case (state)
      T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      T1: begin
        MDMuxread = 1'b1;
        MDRin     = 1'b1;
        if (t1_first) begin
          Zlowout = 1'b1;
          PCin    = 1'b1;
        end
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: if (legal) begin
        Yin = 1'b1;
        if (is_muldiv) Rout[ra] = 1'b1;
        else           Rout[rb] = 1'b1;
      end
      T4: if (legal) begin
        alu_op[alu_idx] = 1'b1;
        Zlowin          = 1'b1;
        if (is_binary) Rout[rc] = 1'b1;
        if (is_muldiv) begin
          Rout[rb] = 1'b1;
          Zhighin  = 1'b1;
        end
      end
      T5: begin
        Zlowout = 1'b1;
        if (is_muldiv) LOin    = 1'b1;
        else           Rin[ra] = 1'b1;
      end
      T6: begin
`ifdef ALU_SEQ_MULDIV_EN
        Zhighout = 1'b1;
        HIin     = 1'b1;
`else
        Zhighout = 1'b0;
        HIin     = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  assign halted = (state == HALT);
  assign busy   = (state != IDLE) && (state != HALT);

endmodule
